io_hex_ctrl: RTL and testbench

Parametrised, register-mapped seven-segment display controller for the RISC-V core's I/O space. It drives 1–8 HEX digits from a bus-writable register file and supports per-digit hex-decode or raw-segment mode, per-digit blink, leading-zero blanking and global enable. It sits behind the LSU I/O decoder and replaces hard-wired per-digit hex outputs with a single generic block.

---
 rtl/io_hex_pkg.sv | 37 +++
 rtl/io_hex_ctrl_hex_seg_decode.sv | 11 +
 rtl/io_hex_ctrl.sv | 141 ++++++++++++++
 tb/tb_io_hex_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/io_hex_pkg.sv
// Shared definitions for the seven-segment display controller: register map,
// control bit positions, blank pattern and the hex segment table.
package io_hex_pkg;

  typedef enum logic [2:0] {
    ADDR_DIGITS = 3'd0,
    ADDR_RAW0   = 3'd1,
    ADDR_RAW1   = 3'd2,
    ADDR_MODE   = 3'd3,
    ADDR_BLINK  = 3'd4,
    ADDR_CTRL   = 3'd5,
    ADDR_STATUS = 3'd6,
    ADDR_UNUSED = 3'd7
  } reg_addr_e;

  localparam logic [6:0] SEG_BLANK    = 7'h7F;
  localparam int         CTRL_EN_BIT  = 0;
  localparam int         CTRL_LZB_BIT = 1;

  // Active-low segments, bit0 = a .. bit6 = g, indexed by nibble value
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] result;
    result = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) result[8*b +: 8] = new_val[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/io_hex_ctrl_hex_seg_decode.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_seg_decode
  import io_hex_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/io_hex_ctrl.sv
// Register-mapped seven-segment controller: bus register file, blink timer,
// leading-zero blanking and registered segment outputs for 1..8 digits.
module io_hex_ctrl
  import io_hex_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_wr_en,
  input  logic                    i_rd_en,
  input  logic [2:0]              i_addr,
  input  logic [31:0]             i_wr_data,
  input  logic [3:0]              i_wr_strb,
  output logic [31:0]             o_rd_data,
  output logic                    o_rd_vld,
  output logic [7*NUM_DIGITS-1:0] o_hex
);

  localparam int                CNT_W    = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_DIV - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("io_hex_ctrl: NUM_DIGITS must be in 1..8");
  end
  if (BLINK_DIV < 2) begin : g_bad_blink_div
    $error("io_hex_ctrl: BLINK_DIV must be at least 2");
  end

  logic [31:0]            digits_q;
  logic [31:0]            raw0_q;
  logic [31:0]            raw1_q;
  logic [7:0]             mode_q;
  logic [7:0]             blink_q;
  logic [1:0]             ctrl_q;
  logic [CNT_W-1:0]       blink_cnt_q;
  logic                   phase_q;
  logic [31:0]            rd_mux;
  logic [63:0]            raw_all;
  logic [NUM_DIGITS-1:0]  lz_blank;
  logic [7*NUM_DIGITS-1:0] hex_next;
  logic [6:0]             dec_seg [NUM_DIGITS];
  logic                   unused_bits;

  // Register file; bits of absent digits are still stored so they read back
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      digits_q <= '0;
      raw0_q   <= '0;
      raw1_q   <= '0;
      mode_q   <= '0;
      blink_q  <= '0;
      ctrl_q   <= 2'b01;
    end else if (i_wr_en) begin
      case (reg_addr_e'(i_addr))
        ADDR_DIGITS: digits_q <= merge_bytes(digits_q, i_wr_data, i_wr_strb);
        ADDR_RAW0:   raw0_q   <= merge_bytes(raw0_q, i_wr_data, i_wr_strb);
        ADDR_RAW1:   raw1_q   <= merge_bytes(raw1_q, i_wr_data, i_wr_strb);
        ADDR_MODE:   if (i_wr_strb[0]) mode_q  <= i_wr_data[7:0];
        ADDR_BLINK:  if (i_wr_strb[0]) blink_q <= i_wr_data[7:0];
        ADDR_CTRL:   if (i_wr_strb[0]) ctrl_q  <= i_wr_data[1:0];
        default: ;
      endcase
    end
  end

  // Free-running blink timer, untouched by register writes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == CNT_LAST) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr_e'(i_addr))
      ADDR_DIGITS: rd_mux = digits_q;
      ADDR_RAW0:   rd_mux = raw0_q;
      ADDR_RAW1:   rd_mux = raw1_q;
      ADDR_MODE:   rd_mux = {24'h0, mode_q};
      ADDR_BLINK:  rd_mux = {24'h0, blink_q};
      ADDR_CTRL:   rd_mux = {30'h0, ctrl_q};
      ADDR_STATUS: rd_mux = {31'h0, phase_q};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_vld  <= 1'b0;
      o_rd_data <= '0;
    end else begin
      o_rd_vld <= i_rd_en;
      if (i_rd_en) o_rd_data <= rd_mux;
    end
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    hex_seg_decode u_dec (
      .nibble (digits_q[4*d +: 4]),
      .seg    (dec_seg[d])
    );
  end

  assign raw_all     = {raw1_q, raw0_q};
  assign unused_bits = ^{raw_all, digits_q, mode_q, blink_q};

  // Leading-zero run starts at the top digit and ends at the first raw or non-zero digit
  always_comb begin
    logic zero_run;
    lz_blank = '0;
    hex_next = '1;
    zero_run = ctrl_q[CTRL_LZB_BIT];
    for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
      zero_run    = zero_run && !mode_q[d] && (digits_q[4*d +: 4] == 4'h0);
      lz_blank[d] = zero_run;
    end
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (!ctrl_q[CTRL_EN_BIT] || (phase_q && blink_q[d]) || lz_blank[d]) begin
        hex_next[7*d +: 7] = SEG_BLANK;
      end else if (mode_q[d]) begin
        hex_next[7*d +: 7] = ~raw_all[8*d +: 7];
      end else begin
        hex_next[7*d +: 7] = dec_seg[d];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) o_hex <= {NUM_DIGITS{SEG_BLANK}};
    else       o_hex <= hex_next;
  end

endmodule

// File: tb/tb_io_hex_ctrl.sv
// Randomised and directed bench for io_hex_ctrl against a cycle-count based
// behavioural model of the register file, blink phase and display rules.
module tb_io_hex_ctrl;

  localparam int ND   = 8;
  localparam int BDIV = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic          rd_en;
  logic [2:0]    addr;
  logic [31:0]   wr_data;
  logic [3:0]    wr_strb;
  logic [31:0]   rd_data;
  logic          rd_vld;
  logic [7*ND-1:0] hex;

  always #5 clk = ~clk;

  io_hex_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BDIV)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr_en   (wr_en),
    .i_rd_en   (rd_en),
    .i_addr    (addr),
    .i_wr_data (wr_data),
    .i_wr_strb (wr_strb),
    .o_rd_data (rd_data),
    .o_rd_vld  (rd_vld),
    .o_hex     (hex)
  );

  localparam logic [6:0] SEG_REF [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic [31:0] m_reg [8];
  int          m_ticks;
  int          pass_count  = 0;
  int          check_count = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
    m_reg[5] = 32'h1;
    m_ticks  = 0;
  endfunction

  // Phase is a pure function of edges elapsed since reset release
  function automatic logic modelPhase();
    return ((m_ticks / BDIV) % 2) == 1;
  endfunction

  function automatic logic [31:0] modelRead(input logic [2:0] a);
    if (a == 3'd6) return {31'h0, modelPhase()};
    if (a == 3'd7) return 32'h0;
    return m_reg[a];
  endfunction

  function automatic void modelWrite(input logic [2:0] a, input logic [31:0] d,
                                     input logic [3:0] s);
    if (a <= 3'd5) begin
      for (int b = 0; b < 4; b++) if (s[b]) m_reg[a][8*b +: 8] = d[8*b +: 8];
      if (a == 3'd3 || a == 3'd4) m_reg[a] = m_reg[a] & 32'hFF;
      if (a == 3'd5) m_reg[a] = m_reg[a] & 32'h3;
    end
  endfunction

  function automatic logic [7*ND-1:0] expHex();
    logic [7*ND-1:0] r;
    logic [3:0]      nib;
    logic [7:0]      raw;
    logic            blanked;
    logic            all_zero;
    r = '0;
    for (int d = 0; d < ND; d++) begin
      nib     = m_reg[0][4*d +: 4];
      raw     = (d < 4) ? m_reg[1][8*d +: 8] : m_reg[2][8*(d-4) +: 8];
      blanked = 1'b0;
      if (m_reg[5][0] == 1'b0) blanked = 1'b1;
      if (modelPhase() && m_reg[4][d]) blanked = 1'b1;
      if (m_reg[5][1] && d > 0) begin
        all_zero = 1'b1;
        for (int j = d; j < ND; j++) begin
          if (m_reg[3][j] || m_reg[0][4*j +: 4] != 4'h0) all_zero = 1'b0;
        end
        if (all_zero) blanked = 1'b1;
      end
      if (blanked)          r[7*d +: 7] = 7'h7F;
      else if (m_reg[3][d]) r[7*d +: 7] = ~raw[6:0];
      else                  r[7*d +: 7] = SEG_REF[nib];
    end
    return r;
  endfunction

  // One clock of stimulus, model update and full output comparison
  task automatic applyStimulus(input logic r, input logic we, input logic re,
                               input logic [2:0] a, input logic [31:0] d,
                               input logic [3:0] s);
    logic [7*ND-1:0] e_hex;
    logic            e_vld;
    logic [31:0]     e_rd;
    rst = r; wr_en = we; rd_en = re; addr = a; wr_data = d; wr_strb = s;
    @(posedge clk);
    e_hex = r ? {ND{7'h7F}} : expHex();
    e_vld = !r && re;
    e_rd  = r ? 32'h0 : modelRead(a);
    if (r) modelReset();
    else begin
      if (we) modelWrite(a, d, s);
      m_ticks++;
    end
    #1;
    checkOutput("o_hex", hex, e_hex);
    checkOutput("o_rd_vld", rd_vld, e_vld);
    if (e_vld || r) checkOutput("o_rd_data", rd_data, e_rd);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    applyStimulus(1'b0, 1'b1, 1'b0, a, d, s);
  endtask

  task automatic rd(input logic [2:0] a);
    applyStimulus(1'b0, 1'b0, 1'b1, a, 32'h0, 4'h0);
  endtask

  initial begin
    logic       r_r, r_we, r_re;
    logic [2:0] r_a;
    logic [31:0] r_d;
    modelReset();

    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    idle();
    checkOutput("post_reset_hex", hex, {ND{7'h40}});
    rd(3'd5);
    checkOutput("ctrl_reset", rd_data, 32'h1);

    wr(3'd0, 32'h0123_ABCD, 4'hF);
    idle();
    checkOutput("digits_decode", hex,
                {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h21});
    wr(3'd0, 32'h0000_00FF, 4'b0001);
    idle();
    checkOutput("byte_strobe", hex,
                {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h0E, 7'h0E});

    wr(3'd0, 32'h0000_0500, 4'hF);
    wr(3'd5, 32'h3, 4'hF);
    idle();
    checkOutput("lz_blank", hex,
                {{5{7'h7F}}, 7'h12, 7'h40, 7'h40});
    wr(3'd0, 32'h0, 4'hF);
    idle();
    checkOutput("lz_all_zero", hex, {{7{7'h7F}}, 7'h40});

    wr(3'd3, 32'h1, 4'hF);
    wr(3'd1, 32'h49, 4'b0001);
    idle();
    checkOutput("raw_digit0", hex, {{7{7'h7F}}, 7'h36});
    wr(3'd2, 32'h4900_0000, 4'hF);
    wr(3'd3, 32'h81, 4'hF);
    idle();
    checkOutput("raw_stops_lz", hex, {7'h36, {6{7'h40}}, 7'h36});

    wr(3'd0, 32'h1234_5678, 4'hF);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 32'h5555_AAAA, 4'hF);
    checkOutput("read_before_write", rd_data, 32'h1234_5678);
    rd(3'd0);

    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 4'h0);
    checkOutput("reset_kills_read", rd_vld, 1'b0);
    rd(3'd0);
    rd(3'd3);
    rd(3'd7);

    wr(3'd4, 32'h1, 4'hF);
    for (int i = 0; i < 20; i++) rd(3'd6);
    wr(3'd5, 32'h0, 4'hF);
    idle();
    checkOutput("disable_blanks", hex, {ND{7'h7F}});
    repeat (6) idle();

    for (int i = 0; i < 600; i++) begin
      r_r  = ($urandom_range(0, 63) == 0);
      r_we = $urandom_range(0, 1) == 1;
      r_re = $urandom_range(0, 1) == 1;
      r_a  = 3'($urandom_range(0, 7));
      r_d  = $urandom;
      if (r_a == 3'd0 && $urandom_range(0, 1) == 1) r_d = r_d & 32'h0F00_00F0;
      if (r_a == 3'd5 && $urandom_range(0, 3) != 0) r_d = r_d | 32'h1;
      applyStimulus(r_r, r_we, r_re, r_a, r_d, 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
